regfile_sequencer: RTL and testbench

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

---
 rtl/regfile_sequencer.sv | 131 +++++++++++++
 tb/tb_regfile_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// Four-state command sequencer that drives an external 3-port register file:
// it reads two operands, computes LI/MOV/ADD/SUB, then writes the result back.
module regfile_sequencer #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [2:0]   cmd_rd,
   input  logic [2:0]   cmd_rs,
   input  logic [2:0]   cmd_rt,
   input  logic [N-1:0] cmd_imm,
   output logic [2:0]   ra1,
   output logic [2:0]   ra2,
   input  logic [N-1:0] rd1,
   input  logic [N-1:0] rd2,
   output logic [2:0]   wa3,
   output logic [N-1:0] wd3,
   output logic         we3,
   output logic         done,
   output logic [N-1:0] result,
   output logic         carry
);

   typedef enum logic [1:0] {StIdle, StRead, StExec, StWrite} state_t;

   localparam logic [1:0] OpLi  = 2'b00;
   localparam logic [1:0] OpMov = 2'b01;
   localparam logic [1:0] OpAdd = 2'b10;
   localparam logic [1:0] OpSub = 2'b11;

   state_t         r_state;
   state_t         w_state_next;
   logic [1:0]     r_op;
   logic [2:0]     r_rd;
   logic [2:0]     r_rs;
   logic [2:0]     r_rt;
   logic [N-1:0]   r_imm;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic [N-1:0]   r_result;
   logic           r_carry;
   logic [N:0]     w_sum;
   logic [N:0]     w_diff;
   logic [N-1:0]   w_exec_result;
   logic           w_exec_carry;
   logic           w_accept;

   assign w_accept = (r_state == StIdle) && cmd_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (cmd_valid) w_state_next = StRead;
         StRead:  w_state_next = StExec;
         StExec:  w_state_next = StWrite;
         StWrite: w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   // Extra top bit gives carry for ADD and, for SUB, is set exactly when A < B.
   always_comb begin
      w_sum         = {1'b0, r_a} + {1'b0, r_b};
      w_diff        = {1'b0, r_a} - {1'b0, r_b};
      w_exec_result = r_imm;
      w_exec_carry  = 1'b0;
      unique case (r_op)
         OpLi:    begin w_exec_result = r_imm; w_exec_carry = 1'b0;      end
         OpMov:   begin w_exec_result = r_a;   w_exec_carry = 1'b0;      end
         OpAdd:   begin w_exec_result = w_sum[N-1:0];  w_exec_carry = w_sum[N];  end
         OpSub:   begin w_exec_result = w_diff[N-1:0]; w_exec_carry = w_diff[N]; end
         default: begin w_exec_result = r_imm; w_exec_carry = 1'b0;      end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op     <= 2'b00;
         r_rd     <= 3'd0;
         r_rs     <= 3'd0;
         r_rt     <= 3'd0;
         r_imm    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op  <= cmd_op;
            r_rd  <= cmd_rd;
            r_rs  <= cmd_rs;
            r_rt  <= cmd_rt;
            r_imm <= cmd_imm;
         end
         if (r_state == StRead) begin
            r_a <= rd1;
            r_b <= rd2;
         end
         if (r_state == StExec) begin
            r_result <= w_exec_result;
            r_carry  <= w_exec_carry;
         end
      end
   end

   // Register 0 is read-only: the write is suppressed but done still pulses.
   always_comb begin
      cmd_ready = (r_state == StIdle);
      done      = (r_state == StWrite);
      we3       = (r_state == StWrite) && (r_rd != 3'd0);
      wa3       = (r_state == StWrite) ? r_rd : 3'd0;
      wd3       = (r_state == StWrite) ? r_result : '0;
   end

   assign ra1    = r_rs;
   assign ra2    = r_rt;
   assign result = r_result;
   assign carry  = r_carry;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a behavioural 8x8 register file
// attached to its read/write ports.
module tb_regfile_sequencer;

   localparam int unsigned N = 8;

   logic         clk;
   logic         rst;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [1:0]   cmd_op;
   logic [2:0]   cmd_rd;
   logic [2:0]   cmd_rs;
   logic [2:0]   cmd_rt;
   logic [N-1:0] cmd_imm;
   logic [2:0]   ra1;
   logic [2:0]   ra2;
   logic [N-1:0] rd1;
   logic [N-1:0] rd2;
   logic [2:0]   wa3;
   logic [N-1:0] wd3;
   logic         we3;
   logic         done;
   logic [N-1:0] result;
   logic         carry;

   logic [N-1:0] rf [8];
   int           n_vec;
   int           n_err;
   int           n_we;

   regfile_sequencer #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_rd    (cmd_rd),
      .cmd_rs    (cmd_rs),
      .cmd_rt    (cmd_rt),
      .cmd_imm   (cmd_imm),
      .ra1       (ra1),
      .ra2       (ra2),
      .rd1       (rd1),
      .rd2       (rd2),
      .wa3       (wa3),
      .wd3       (wd3),
      .we3       (we3),
      .done      (done),
      .result    (result),
      .carry     (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign rd1 = rf[ra1];
   assign rd2 = rf[ra2];

   always @(posedge clk) begin
      if (we3) begin
         rf[wa3] <= wd3;
         n_we    <= n_we + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accept edge, then READ, EXEC, WRITE, back to IDLE, checked 1 time unit after each edge.
   task automatic run_cmd(input string tag, input logic [1:0] op, input logic [2:0] rd,
                          input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm,
                          input logic [7:0] exp_wd, input logic exp_c, input logic exp_we);
      @(negedge clk);
      check({tag, " ready_before"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt; cmd_imm = imm;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check({tag, " read_ready"}, cmd_ready, 0);
      check({tag, " read_we"}, we3, 0);
      @(posedge clk); #1;
      check({tag, " exec_ready"}, cmd_ready, 0);
      check({tag, " exec_we_done"}, {we3, done}, 0);
      @(posedge clk); #1;
      check({tag, " wr_done"}, done, 1);
      check({tag, " wr_we"}, we3, exp_we);
      check({tag, " wr_wa3"}, wa3, rd);
      check({tag, " wr_wd3"}, wd3, exp_wd);
      check({tag, " wr_carry"}, carry, exp_c);
      check({tag, " wr_ready"}, cmd_ready, 0);
      @(posedge clk); #1;
      check({tag, " idle_ready"}, cmd_ready, 1);
      check({tag, " idle_we_done"}, {we3, done}, 0);
      check({tag, " idle_wa_wd"}, {wa3, wd3}, 0);
      check({tag, " hold_result"}, {carry, result}, {exp_c, exp_wd});
   endtask

   initial begin
      int we_snap;
      n_vec = 0; n_err = 0; n_we = 0;
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
      cmd_rd = 3'd0; cmd_rs = 3'd0; cmd_rt = 3'd0; cmd_imm = '0;
      for (int i = 0; i < 8; i++) rf[i] = '0;
      #12;
      check("rst ready", cmd_ready, 1);
      check("rst we_done", {we3, done}, 0);
      check("rst result_carry", {carry, result}, 0);
      check("rst addrs", {ra1, ra2, wa3}, 0);
      check("rst wd3", wd3, 0);
      @(negedge clk); rst = 1'b1;

      run_cmd("li3", 2'b00, 3'd3, 3'd0, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b1);
      check("rf3", rf[3], 8'h5A);

      run_cmd("li1", 2'b00, 3'd1, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b1);
      run_cmd("li2", 2'b00, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 1'b1);
      run_cmd("add", 2'b10, 3'd4, 3'd1, 3'd2, 8'h00, 8'h10, 1'b1, 1'b1);
      check("rf4", rf[4], 8'h10);

      run_cmd("li1b", 2'b00, 3'd1, 3'd0, 3'd0, 8'h05, 8'h05, 1'b0, 1'b1);
      run_cmd("li2b", 2'b00, 3'd2, 3'd0, 3'd0, 8'h07, 8'h07, 1'b0, 1'b1);
      run_cmd("sub_borrow", 2'b11, 3'd5, 3'd1, 3'd2, 8'h00, 8'hFE, 1'b1, 1'b1);
      run_cmd("sub_plain", 2'b11, 3'd5, 3'd2, 3'd1, 8'h00, 8'h02, 1'b0, 1'b1);
      check("rf5", rf[5], 8'h02);
      // rd equal to a source: operands are the pre-write values.
      run_cmd("add_self", 2'b10, 3'd1, 3'd1, 3'd1, 8'h00, 8'h0A, 1'b0, 1'b1);

      run_cmd("li6", 2'b00, 3'd6, 3'd0, 3'd0, 8'h33, 8'h33, 1'b0, 1'b1);
      we_snap = n_we;
      run_cmd("mov_r0", 2'b01, 3'd0, 3'd6, 3'd0, 8'h00, 8'h33, 1'b0, 1'b0);
      check("mov_r0 no_write", n_we - we_snap, 0);
      check("rf0", rf[0], 8'h00);

      // Busy: valid stays high, fields change mid-flight; second command waits for IDLE.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rd = 3'd7; cmd_imm = 8'h11;
      @(posedge clk); #1;
      cmd_rd = 3'd1; cmd_imm = 8'h99;
      check("busy read_ready", cmd_ready, 0);
      @(posedge clk); #1;
      check("busy exec_ready", cmd_ready, 0);
      @(posedge clk); #1;
      check("busy wr_wa3", wa3, 3'd7);
      check("busy wr_wd3", wd3, 8'h11);
      check("busy wr_we", we3, 1);
      @(posedge clk); #1;
      check("busy idle_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      check("busy2 read_ready", cmd_ready, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("busy2 wr_wa3", wa3, 3'd1);
      check("busy2 wr_wd3", wd3, 8'h99);
      @(posedge clk); #1;
      check("rf7", rf[7], 8'h11);
      check("rf1", rf[1], 8'h99);

      // Reset asserted during EXEC of an ADD aimed at r6.
      we_snap = n_we;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_rd = 3'd6; cmd_rs = 3'd1; cmd_rt = 3'd2;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("midrst ready", cmd_ready, 1);
      check("midrst we_done", {we3, done}, 0);
      check("midrst result_carry", {carry, result}, 0);
      check("midrst addrs", {ra1, ra2, wa3}, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("midrst held_idle", {cmd_ready, we3, done}, 3'b100);
      @(negedge clk); rst = 1'b1;
      check("midrst no_write", n_we - we_snap, 0);
      check("rf6 kept", rf[6], 8'h33);
      run_cmd("after_rst", 2'b00, 3'd2, 3'd0, 3'd0, 8'h3C, 8'h3C, 1'b0, 1'b1);
      check("rf2", rf[2], 8'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
